noc_ip_endpoint: RTL and testbench
==================================

Name: noc_ip_endpoint

Overview:
- IP-side endpoint for one noc_stop IP port.
- Converts a core's valid/ready send and receive streams into the stop's port handshake: tx_submit/tx_complete on the send side and rx_recieve/rx_complete on the receive side.
- Buffers outbound and inbound packets in small FIFOs and keeps traffic counters.
- One instance per IP port, between the core logic and noc_stop.

Parameters:
- ADDR, 0, this stop's 8-bit address; used as src_addr on TX and checked against dst_addr on RX.
- PRT, 0, this port's index; used as src_prt on TX and checked against dst_prt on RX.
- PAY_W, 32, payload width in bits.
- TXQ_DEPTH, 4, TX FIFO depth; power of 2, at least 2.
- RXQ_DEPTH, 4, RX FIFO depth; power of 2, at least 2.

Ports:
- clk  in  1  single clock for the whole block.
- rst  in  1  synchronous reset, active-high.
- core_tx_valid  in  1  core has a packet to send.
- core_tx_ready  out  1  TX FIFO not full.
- core_tx_dst_addr  in  8  destination stop address.
- core_tx_dst_prt  in  4  destination port index.
- core_tx_payload  in  PAY_W  payload to send.
- core_rx_valid  out  1  RX FIFO not empty.
- core_rx_ready  in  1  core accepts the RX FIFO head.
- core_rx_src_addr  out  8  source stop address of the RX head.
- core_rx_src_prt  out  4  source port of the RX head.
- core_rx_payload  out  PAY_W  payload of the RX head.
- to_noc_prt_stat  in  noc_port_status  send side may submit only when equal to port_open.
- tx_submit  out  1  dat_to_noc holds a packet for the stop.
- dat_to_noc  out  PAY_W+24  packet to the stop.
- tx_complete  in  1  stop accepted the packet this cycle.
- from_noc_prt_stat  in  noc_port_status  receive side may accept only when equal to port_open.
- rx_recieve  in  1  stop presents a packet on dat_from_noc.
- dat_from_noc  in  PAY_W+24  packet from the stop.
- rx_complete  out  1  one-cycle accept pulse; the stop shifts its receive queue on it.
- tx_sent_cnt  out  16  packets accepted by the stop; wraps.
- rx_rcvd_cnt  out  16  packets delivered into the RX FIFO; wraps.
- rx_misroute_cnt  out  16  packets whose dst does not match ADDR/PRT; saturates at 16'hFFFF.

Behaviour:
- Packet layout, MSB first: dst_addr[7:0], dst_prt[3:0], src_addr[7:0], src_prt[3:0], payload[PAY_W-1:0].
- Reset (synchronous, while rst is high):
  - Both FIFOs empty, both FSMs idle.
  - tx_submit=0, dat_to_noc=0, rx_complete=0.
  - core_tx_ready=1 (FIFO is empty), core_rx_valid=0.
  - All counters 0.
  - A reset mid-handshake drops the in-flight packet and deasserts tx_submit/rx_complete on the next edge.
- TX FIFO:
  - Push on core_tx_valid && core_tx_ready; the pushed entry is {dst_addr, dst_prt, ADDR, PRT, payload}.
  - core_tx_ready = !full. A pop in the same cycle does not raise ready (no bypass).
  - Push and pop in the same cycle are both performed.
- TX FSM:
  - TX_IDLE: if the FIFO is not empty and to_noc_prt_stat==port_open, register the FIFO head into dat_to_noc, set tx_submit=1, go to TX_SUB.
  - TX_SUB: tx_submit and dat_to_noc are held stable, regardless of port status, until tx_complete is sampled high.
  - On tx_complete: pop the FIFO, increment tx_sent_cnt, tx_submit=0, dat_to_noc=0, go to TX_IDLE.
  - Minimum spacing is one idle cycle between submits, so the maximum rate is one packet per 2 cycles.
  - tx_complete while in TX_IDLE is ignored.
- RX FSM:
  - RX_IDLE: if rx_recieve && from_noc_prt_stat==port_open && RX FIFO not full, capture dat_from_noc, set rx_complete=1, go to RX_ACK.
    - Captured dst matches ADDR/PRT: push {src_addr, src_prt, payload} into the RX FIFO and increment rx_rcvd_cnt.
    - Otherwise: do not push, and increment rx_misroute_cnt. The packet is still acknowledged.
  - RX_ACK: rx_complete=0, go to RX_WAIT.
  - RX_WAIT: rx_recieve is ignored for this one cycle while the stop's queue output settles; go to RX_IDLE.
  - Maximum rate is one packet per 3 cycles.
  - RX FIFO full: stay in RX_IDLE with rx_complete=0 (backpressure). Nothing is lost.
- RX FIFO output:
  - core_rx_* show the head combinationally.
  - Pop on core_rx_valid && core_rx_ready.
  - Push and pop in the same cycle are both performed.
  - A pop does not free space for a push decided in that same cycle; full is evaluated from the registered count.
- FIFOs:
  - Read/write pointers of log2(DEPTH) bits plus a count register of log2(DEPTH)+1 bits.
  - Pointers wrap modulo DEPTH.

Test Plan:
- Single send, ADDR=3, PRT=1: push {dst=5, prt=2, pay=0xDEADBEEF}, stop raises tx_complete 3 cycles after tx_submit rises -> dat_to_noc={8'h05, 4'h2, 8'h03, 4'h1, 32'hDEADBEEF}, held stable for all 3 cycles; tx_sent_cnt=1; FIFO empty.
- TX FIFO full: push 4 packets with tx_complete held 0 -> core_tx_ready=0 after the 4th push. One tx_complete -> ready=1 on the following cycle and the next head is submitted after one idle cycle.
- Port closed: to_noc_prt_stat != port_open with a non-empty FIFO -> tx_submit stays 0. Reopen -> tx_submit=1 on the next cycle.
- RX backpressure: 5 packets to ADDR/PRT with core_rx_ready=0 -> 4 rx_complete pulses, each exactly 1 cycle and at least 3 cycles apart; the 5th packet is held by the stop. Popping one -> the 5th is accepted; rx_rcvd_cnt=5.
- Misroute: RX packet with dst_prt=PRT+1 -> rx_complete pulses, FIFO unchanged, rx_misroute_cnt=1.
- Reset mid-TX: rst pulsed during TX_SUB -> tx_submit=0 on the next cycle, counters 0, FIFOs empty, core_tx_ready=1.

Source files
------------

// File: rtl/noc_ip_endpoint_if.sv
// noc_ip_endpoint_if: port status type plus core stream / noc_stop port handshake bundle
package noc_ip_endpoint_pkg;
  typedef enum logic [1:0] {port_closed, port_open, port_busy, port_error} noc_port_status;
endpackage

interface noc_ip_endpoint_if #(parameter int PAY_W = 32) ();
  import noc_ip_endpoint_pkg::*;
  logic               core_tx_valid;
  logic               core_tx_ready;
  logic [7:0]         core_tx_dst_addr;
  logic [3:0]         core_tx_dst_prt;
  logic [PAY_W-1:0]   core_tx_payload;
  logic               core_rx_valid;
  logic               core_rx_ready;
  logic [7:0]         core_rx_src_addr;
  logic [3:0]         core_rx_src_prt;
  logic [PAY_W-1:0]   core_rx_payload;
  noc_port_status     to_noc_prt_stat;
  logic               tx_submit;
  logic [PAY_W+23:0]  dat_to_noc;
  logic               tx_complete;
  noc_port_status     from_noc_prt_stat;
  logic               rx_recieve;
  logic [PAY_W+23:0]  dat_from_noc;
  logic               rx_complete;
  modport slave (
    input  core_tx_valid, core_tx_dst_addr, core_tx_dst_prt, core_tx_payload, core_rx_ready,
    input  to_noc_prt_stat, tx_complete, from_noc_prt_stat, rx_recieve, dat_from_noc,
    output core_tx_ready, core_rx_valid, core_rx_src_addr, core_rx_src_prt, core_rx_payload,
    output tx_submit, dat_to_noc, rx_complete
  );
  modport master (
    output core_tx_valid, core_tx_dst_addr, core_tx_dst_prt, core_tx_payload, core_rx_ready,
    output to_noc_prt_stat, tx_complete, from_noc_prt_stat, rx_recieve, dat_from_noc,
    input  core_tx_ready, core_rx_valid, core_rx_src_addr, core_rx_src_prt, core_rx_payload,
    input  tx_submit, dat_to_noc, rx_complete
  );
endinterface

// File: rtl/noc_ip_endpoint.sv
// noc_ip_endpoint: core valid/ready streams to noc_stop port handshake with TX/RX FIFOs and counters
module noc_ip_endpoint
  import noc_ip_endpoint_pkg::*;
#(
  parameter logic [7:0] ADDR      = 8'd0,
  parameter logic [3:0] PRT       = 4'd0,
  parameter int         PAY_W     = 32,
  parameter int         TXQ_DEPTH = 4,
  parameter int         RXQ_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  noc_ip_endpoint_if.slave  bus,
  output logic [15:0]       tx_sent_cnt,
  output logic [15:0]       rx_rcvd_cnt,
  output logic [15:0]       rx_misroute_cnt
);
  localparam int PW = PAY_W + 24;
  localparam int RW = PAY_W + 12;
  localparam int TA = $clog2(TXQ_DEPTH);
  localparam int RA = $clog2(RXQ_DEPTH);
  typedef enum logic {TX_IDLE, TX_SUB} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_ACK, RX_WAIT} rx_state_t;
  tx_state_t     r_tx_st;
  rx_state_t     r_rx_st;
  logic [PW-1:0] r_txq [TXQ_DEPTH];
  logic [TA-1:0] r_tx_wp;
  logic [TA-1:0] r_tx_rp;
  logic [TA:0]   r_tx_cnt;
  logic [RW-1:0] r_rxq [RXQ_DEPTH];
  logic [RA-1:0] r_rx_wp;
  logic [RA-1:0] r_rx_rp;
  logic [RA:0]   r_rx_cnt;
  logic          r_tx_submit;
  logic          r_rx_complete;
  logic [PW-1:0] r_dat_to_noc;
  logic          w_tx_push;
  logic          w_tx_pop;
  logic          w_rx_acc;
  logic          w_rx_match;
  logic          w_rx_push;
  logic          w_rx_pop;
  assign bus.core_tx_ready = r_tx_cnt != (TA+1)'(TXQ_DEPTH);
  assign bus.core_rx_valid = r_rx_cnt != '0;
  assign {bus.core_rx_src_addr, bus.core_rx_src_prt, bus.core_rx_payload} = r_rxq[r_rx_rp];
  assign bus.tx_submit   = r_tx_submit;
  assign bus.dat_to_noc  = r_dat_to_noc;
  assign bus.rx_complete = r_rx_complete;
  assign w_tx_push  = bus.core_tx_valid && bus.core_tx_ready;
  assign w_tx_pop   = r_tx_st == TX_SUB && bus.tx_complete;
  assign w_rx_acc   = r_rx_st == RX_IDLE && bus.rx_recieve && bus.from_noc_prt_stat == port_open &&
                      r_rx_cnt != (RA+1)'(RXQ_DEPTH);
  assign w_rx_match = bus.dat_from_noc[PW-1 -: 8] == ADDR && bus.dat_from_noc[PW-9 -: 4] == PRT;
  assign w_rx_push  = w_rx_acc && w_rx_match;
  assign w_rx_pop   = bus.core_rx_valid && bus.core_rx_ready;
  always_ff @(posedge clk) begin
    if (w_tx_push) r_txq[r_tx_wp] <= {bus.core_tx_dst_addr, bus.core_tx_dst_prt, ADDR, PRT, bus.core_tx_payload};
    if (w_rx_push) r_rxq[r_rx_wp] <= bus.dat_from_noc[RW-1:0];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx_wp      <= '0;
      r_tx_rp      <= '0;
      r_tx_cnt     <= '0;
      r_tx_st      <= TX_IDLE;
      r_tx_submit  <= 1'b0;
      r_dat_to_noc <= '0;
      tx_sent_cnt  <= '0;
    end else begin
      r_tx_wp  <= w_tx_push ? r_tx_wp + TA'(1) : r_tx_wp;
      r_tx_rp  <= w_tx_pop ? r_tx_rp + TA'(1) : r_tx_rp;
      r_tx_cnt <= r_tx_cnt + (TA+1)'(w_tx_push) - (TA+1)'(w_tx_pop);
      case (r_tx_st)
        TX_IDLE: if (r_tx_cnt != '0 && bus.to_noc_prt_stat == port_open) begin
          r_dat_to_noc <= r_txq[r_tx_rp];
          r_tx_submit  <= 1'b1;
          r_tx_st      <= TX_SUB;
        end
        TX_SUB: if (bus.tx_complete) begin
          r_dat_to_noc <= '0;
          r_tx_submit  <= 1'b0;
          tx_sent_cnt  <= tx_sent_cnt + 16'd1;
          r_tx_st      <= TX_IDLE;
        end
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_wp         <= '0;
      r_rx_rp         <= '0;
      r_rx_cnt        <= '0;
      r_rx_st         <= RX_IDLE;
      r_rx_complete   <= 1'b0;
      rx_rcvd_cnt     <= '0;
      rx_misroute_cnt <= '0;
    end else begin
      r_rx_wp  <= w_rx_push ? r_rx_wp + RA'(1) : r_rx_wp;
      r_rx_rp  <= w_rx_pop ? r_rx_rp + RA'(1) : r_rx_rp;
      r_rx_cnt <= r_rx_cnt + (RA+1)'(w_rx_push) - (RA+1)'(w_rx_pop);
      case (r_rx_st)
        RX_IDLE: if (w_rx_acc) begin
          r_rx_complete   <= 1'b1;
          r_rx_st         <= RX_ACK;
          rx_rcvd_cnt     <= w_rx_match ? rx_rcvd_cnt + 16'd1 : rx_rcvd_cnt;
          rx_misroute_cnt <= !w_rx_match && rx_misroute_cnt != 16'hFFFF ? rx_misroute_cnt + 16'd1 : rx_misroute_cnt;
        end
        RX_ACK: begin
          r_rx_complete <= 1'b0;
          r_rx_st       <= RX_WAIT;
        end
        default: r_rx_st <= RX_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_noc_ip_endpoint.sv
// tb_noc_ip_endpoint: vector tables, handshake corner sequences and randomized traffic vs a queue model
module tb_noc_ip_endpoint;
  import noc_ip_endpoint_pkg::*;
  localparam int PAY_W = 32;
  localparam logic [7:0] ADDR = 8'h03;
  localparam logic [3:0] PRT  = 4'h1;
  typedef struct {
    logic [7:0]  da;
    logic [3:0]  dp;
    logic [31:0] pay;
    int          dly;
    logic [55:0] exp_pkt;
  } tx_vec_t;
  typedef struct {
    logic [55:0] pkt;
    logic        match;
  } rx_vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [15:0] tx_sent_cnt, rx_rcvd_cnt, rx_misroute_cnt;
  int vecs = 0;
  int errs = 0;
  noc_ip_endpoint_if #(.PAY_W(PAY_W)) bus ();
  noc_ip_endpoint #(.ADDR(ADDR), .PRT(PRT), .PAY_W(PAY_W), .TXQ_DEPTH(4), .RXQ_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .tx_sent_cnt(tx_sent_cnt), .rx_rcvd_cnt(rx_rcvd_cnt), .rx_misroute_cnt(rx_misroute_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic idle_in();
    bus.core_tx_valid     = 1'b0;
    bus.core_tx_dst_addr  = '0;
    bus.core_tx_dst_prt   = '0;
    bus.core_tx_payload   = '0;
    bus.core_rx_ready     = 1'b0;
    bus.to_noc_prt_stat   = port_open;
    bus.tx_complete       = 1'b0;
    bus.from_noc_prt_stat = port_open;
    bus.rx_recieve        = 1'b0;
    bus.dat_from_noc      = '0;
  endtask
  task automatic do_reset();
    idle_in();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask
  task automatic check_reset(input string tag);
    chk({tag, "_submit"}, bus.tx_submit, 0);
    chk({tag, "_dat"}, bus.dat_to_noc, 0);
    chk({tag, "_rxc"}, bus.rx_complete, 0);
    chk({tag, "_txrdy"}, bus.core_tx_ready, 1);
    chk({tag, "_rxvld"}, bus.core_rx_valid, 0);
    chk({tag, "_sent"}, tx_sent_cnt, 0);
    chk({tag, "_rcvd"}, rx_rcvd_cnt, 0);
    chk({tag, "_mis"}, rx_misroute_cnt, 0);
  endtask
  task automatic push_tx(input logic [7:0] da, input logic [3:0] dp, input logic [31:0] pay);
    bus.core_tx_valid    = 1'b1;
    bus.core_tx_dst_addr = da;
    bus.core_tx_dst_prt  = dp;
    bus.core_tx_payload  = pay;
    tick();
    bus.core_tx_valid = 1'b0;
  endtask
  tx_vec_t txv [4];
  rx_vec_t rxv [4];
  logic [55:0] bp_pkts [5];
  logic [55:0] txq [$];
  logic [55:0] pend [$];
  logic [43:0] rxq [$];
  logic [55:0] pkt;
  bit drain, push, comp, launch, acc, pop, exp_sub, prev_rxc;
  int rx_busy, sent, rcvd, mis, idx, last;
  initial begin
    txv = '{
      '{8'h05, 4'h2, 32'hDEADBEEF, 3, 56'h05_2_03_1_DEADBEEF},
      '{8'hFF, 4'hF, 32'h00000000, 1, 56'hFF_F_03_1_00000000},
      '{8'h00, 4'h0, 32'h12345678, 2, 56'h00_0_03_1_12345678},
      '{8'hA5, 4'h7, 32'hFFFFFFFF, 5, 56'hA5_7_03_1_FFFFFFFF}
    };
    rxv = '{
      '{56'h03_1_05_2_CAFEF00D, 1'b1},
      '{56'h03_2_07_0_11112222, 1'b0},
      '{56'h04_1_09_3_33334444, 1'b0},
      '{56'h03_1_FF_F_00000001, 1'b1}
    };
    do_reset();
    check_reset("reset");
    for (int i = 0; i < 4; i++) begin
      push_tx(txv[i].da, txv[i].dp, txv[i].pay);
      tick();
      for (int d = 0; d < txv[i].dly; d++) begin
        chk("tx_submit_held", bus.tx_submit, 1);
        chk("tx_dat_held", bus.dat_to_noc, txv[i].exp_pkt);
        bus.tx_complete = (d == txv[i].dly - 1);
        tick();
      end
      bus.tx_complete = 1'b0;
      chk("tx_submit_drop", bus.tx_submit, 0);
      chk("tx_dat_clear", bus.dat_to_noc, 0);
      chk("tx_sent_cnt", tx_sent_cnt, 16'(i + 1));
      chk("tx_ready_empty", bus.core_tx_ready, 1);
      tick();
      chk("tx_no_resubmit", bus.tx_submit, 0);
    end
    do_reset();
    for (int k = 0; k < 4; k++) push_tx(8'(8'h10 + k), 4'(k), 32'(32'h1000 + k));
    chk("full_ready", bus.core_tx_ready, 0);
    chk("full_submit", bus.tx_submit, 1);
    chk("full_dat0", bus.dat_to_noc, {8'h10, 4'h0, ADDR, PRT, 32'h1000});
    tick();
    tick();
    chk("full_ready_hold", bus.core_tx_ready, 0);
    chk("full_dat0_hold", bus.dat_to_noc, {8'h10, 4'h0, ADDR, PRT, 32'h1000});
    bus.tx_complete = 1'b1;
    tick();
    bus.tx_complete = 1'b0;
    chk("full_ready_after_pop", bus.core_tx_ready, 1);
    chk("full_idle_gap", bus.tx_submit, 0);
    tick();
    chk("full_next_submit", bus.tx_submit, 1);
    chk("full_dat1", bus.dat_to_noc, {8'h11, 4'h1, ADDR, PRT, 32'h1001});
    chk("full_sent", tx_sent_cnt, 1);
    do_reset();
    bus.to_noc_prt_stat = port_closed;
    push_tx(8'h22, 4'h3, 32'h55AA55AA);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("closed_no_submit", bus.tx_submit, 0);
    end
    bus.to_noc_prt_stat = port_open;
    tick();
    chk("reopen_submit", bus.tx_submit, 1);
    chk("reopen_dat", bus.dat_to_noc, {8'h22, 4'h3, ADDR, PRT, 32'h55AA55AA});
    bus.to_noc_prt_stat = port_closed;
    tick();
    chk("closed_sub_held", bus.tx_submit, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset("rst_mid_tx");
    bus.to_noc_prt_stat = port_open;
    tick();
    tick();
    chk("rst_dropped_pkt", bus.tx_submit, 0);
    do_reset();
    rcvd = 0;
    mis = 0;
    for (int i = 0; i < 4; i++) begin
      bus.rx_recieve   = 1'b1;
      bus.dat_from_noc = rxv[i].pkt;
      tick();
      bus.rx_recieve = 1'b0;
      chk("rxt_complete", bus.rx_complete, 1);
      if (rxv[i].match) rcvd++;
      else mis++;
      chk("rxt_rcvd", rx_rcvd_cnt, 16'(rcvd));
      chk("rxt_mis", rx_misroute_cnt, 16'(mis));
      chk("rxt_valid", bus.core_rx_valid, rxv[i].match);
      chk("rxt_head", {bus.core_rx_src_addr, bus.core_rx_src_prt, bus.core_rx_payload}, rxv[i].match ? rxv[i].pkt[43:0] : 44'h0 | {bus.core_rx_src_addr, bus.core_rx_src_prt, bus.core_rx_payload});
      bus.core_rx_ready = 1'b1;
      tick();
      bus.core_rx_ready = 1'b0;
      chk("rxt_pulse_end", bus.rx_complete, 0);
      tick();
      chk("rxt_empty", bus.core_rx_valid, 0);
    end
    do_reset();
    for (int k = 0; k < 5; k++) bp_pkts[k] = {ADDR, PRT, 8'(8'h40 + k), 4'(k), 32'(32'hB0000000 + k)};
    idx = 0;
    last = -10;
    prev_rxc = 1'b0;
    for (int c = 0; c < 40; c++) begin
      bus.rx_recieve   = idx < 5;
      bus.dat_from_noc = idx < 5 ? bp_pkts[idx] : '0;
      prev_rxc = bus.rx_complete;
      tick();
      if (bus.rx_complete) begin
        chk("bp_pulse_width", prev_rxc, 0);
        chk("bp_spacing", (c - last) >= 3, 1);
        last = c;
        idx++;
      end
    end
    chk("bp_accepted", idx, 4);
    chk("bp_rcvd", rx_rcvd_cnt, 4);
    chk("bp_head0", {bus.core_rx_src_addr, bus.core_rx_src_prt, bus.core_rx_payload}, bp_pkts[0][43:0]);
    bus.core_rx_ready = 1'b1;
    tick();
    bus.core_rx_ready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      bus.rx_recieve   = idx < 5;
      bus.dat_from_noc = idx < 5 ? bp_pkts[idx] : '0;
      tick();
      if (bus.rx_complete) idx++;
    end
    bus.rx_recieve = 1'b0;
    chk("bp_fifth", idx, 5);
    chk("bp_rcvd5", rx_rcvd_cnt, 5);
    for (int k = 1; k < 5; k++) begin
      chk("bp_head", {bus.core_rx_src_addr, bus.core_rx_src_prt, bus.core_rx_payload}, bp_pkts[k][43:0]);
      bus.core_rx_ready = 1'b1;
      tick();
      bus.core_rx_ready = 1'b0;
    end
    chk("bp_drained", bus.core_rx_valid, 0);
    do_reset();
    exp_sub = 0;
    rx_busy = 0;
    sent = 0;
    rcvd = 0;
    mis = 0;
    for (int c = 0; c < 3000; c++) begin
      drain = c >= 2500;
      if (!drain && pend.size() < 3 && $urandom_range(0, 2) == 0) begin
        if ($urandom_range(0, 4) < 3) pkt = {ADDR, PRT, 8'($urandom), 4'($urandom), 32'($urandom)};
        else pkt = {8'($urandom_range(2, 4)), 4'($urandom_range(0, 2)), 8'($urandom), 4'($urandom), 32'($urandom)};
        pend.push_back(pkt);
      end
      bus.core_tx_valid     = !drain && $urandom_range(0, 1) == 1;
      bus.core_tx_dst_addr  = 8'($urandom);
      bus.core_tx_dst_prt   = 4'($urandom);
      bus.core_tx_payload   = 32'($urandom);
      bus.to_noc_prt_stat   = (drain || $urandom_range(0, 3) != 0) ? port_open : noc_port_status'(2'($urandom));
      bus.tx_complete       = (bus.tx_submit && (drain || $urandom_range(0, 2) == 0)) || $urandom_range(0, 9) == 0;
      bus.from_noc_prt_stat = (drain || $urandom_range(0, 3) != 0) ? port_open : noc_port_status'(2'($urandom));
      bus.rx_recieve        = pend.size() > 0;
      bus.dat_from_noc      = pend.size() > 0 ? pend[0] : '0;
      bus.core_rx_ready     = drain || $urandom_range(0, 3) == 0;
      push   = bus.core_tx_valid && txq.size() < 4;
      comp   = exp_sub && bus.tx_complete;
      launch = !exp_sub && txq.size() > 0 && bus.to_noc_prt_stat == port_open;
      acc    = bus.rx_recieve && bus.from_noc_prt_stat == port_open && rxq.size() < 4 && rx_busy == 0;
      pop    = bus.core_rx_ready && rxq.size() > 0;
      if (pop) chk("rnd_rx_head", {bus.core_rx_src_addr, bus.core_rx_src_prt, bus.core_rx_payload}, rxq[0]);
      pkt = {bus.core_tx_dst_addr, bus.core_tx_dst_prt, ADDR, PRT, bus.core_tx_payload};
      tick();
      if (comp) begin
        void'(txq.pop_front());
        sent++;
        exp_sub = 0;
      end else if (launch) exp_sub = 1;
      if (push) txq.push_back(pkt);
      if (pop) void'(rxq.pop_front());
      if (acc) begin
        pkt = pend.pop_front();
        if (pkt[55:48] == ADDR && pkt[47:44] == PRT) begin
          rxq.push_back(pkt[43:0]);
          rcvd++;
        end else if (mis < 65535) mis++;
        rx_busy = 2;
      end else if (rx_busy > 0) rx_busy--;
      chk("rnd_submit", bus.tx_submit, exp_sub);
      chk("rnd_dat", bus.dat_to_noc, exp_sub ? txq[0] : 56'h0);
      chk("rnd_tx_ready", bus.core_tx_ready, txq.size() < 4);
      chk("rnd_rx_complete", bus.rx_complete, acc);
      chk("rnd_rx_valid", bus.core_rx_valid, rxq.size() > 0);
      chk("rnd_sent", tx_sent_cnt, 16'(sent));
      chk("rnd_rcvd", rx_rcvd_cnt, 16'(rcvd));
      chk("rnd_mis", rx_misroute_cnt, 16'(mis));
    end
    chk("rnd_tx_drained", txq.size(), 0);
    chk("rnd_stop_drained", pend.size(), 0);
    chk("rnd_rx_drained", rxq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
